// File: rtl/uart_pkg.sv
// +------------------------------------------------------------------+
// | uart_pkg : shared UART types and default sizing constants         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FLUSH = 2'd3
  } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_fifo_ctrl_if.sv
// +------------------------------------------------------------------+
// | uart_tx_fifo_ctrl_if : requester, FIFO and transmitter signals    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

interface uart_tx_fifo_ctrl_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = UART_DATA_WIDTH
);

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       gnt;
  logic                     fifo_write_en;
  logic [WIDTH-1:0]         fifo_data_in;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     fifo_read_en;
  logic [WIDTH-1:0]         fifo_data_out;
  logic                     enable;
  logic                     flush;
  logic                     flush_busy;
  logic [WIDTH-1:0]         tx_data;
  logic                     tx_valid;
  logic                     tx_ready;

  modport master (
    input  req, req_data, fifo_full, fifo_empty, fifo_data_out,
           enable, flush, tx_ready,
    output gnt, fifo_write_en, fifo_data_in, fifo_read_en,
           flush_busy, tx_data, tx_valid
  );

  modport slave (
    output req, req_data, fifo_full, fifo_empty, fifo_data_out,
           enable, flush, tx_ready,
    input  gnt, fifo_write_en, fifo_data_in, fifo_read_en,
           flush_busy, tx_data, tx_valid
  );

endinterface

`default_nettype wire

// File: rtl/uart_rr_arbiter.sv
// +------------------------------------------------------------------+
// | uart_rr_arbiter : combinational round-robin grant from a pointer  |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module uart_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               enable,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   next_ptr
);

  logic             w_found;
  logic [PTR_W-1:0] w_idx;

  // Scan from ptr upward with wrap; first requester found wins.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
      if (enable && !w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
        next_ptr   = PTR_W'((int'(w_idx) + 1) % NUM_REQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_tx_fifo_ctrl.sv
// +------------------------------------------------------------------+
// | uart_tx_fifo_ctrl : TX FIFO write arbiter, drain FSM and flush    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int WIDTH      = UART_DATA_WIDTH,
  parameter int DEPTH      = UART_FIFO_DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_fifo_ctrl_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  generate
    if (NUM_REQ < 2 || DEPTH < 2 || ADDR_WIDTH != $clog2(DEPTH)) begin : g_param_check
      $error("uart_tx_fifo_ctrl: invalid NUM_REQ/DEPTH/ADDR_WIDTH");
    end
  endgenerate

  drain_state_t       r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [NUM_REQ-1:0] w_gnt;
  logic               w_arb_en;
  logic [WIDTH-1:0]   w_wdata;
  logic               r_tx_valid, w_tx_valid_nxt;
  logic [WIDTH-1:0]   r_tx_data, w_tx_data_nxt;
  logic               w_read_en;

  // Writes are held off while full and for the whole flush window.
  assign w_arb_en = !rst && !bus.fifo_full && !bus.flush && (r_state != ST_FLUSH);

  uart_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arb (
    .req      (bus.req),
    .enable   (w_arb_en),
    .ptr      (r_rr_ptr),
    .gnt      (w_gnt),
    .next_ptr (w_rr_ptr_nxt)
  );

  always_comb begin
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_wdata = bus.req_data[i*WIDTH +: WIDTH];
    end
  end

  assign bus.gnt           = w_gnt;
  assign bus.fifo_write_en = |w_gnt;
  assign bus.fifo_data_in  = w_wdata;
  assign bus.fifo_read_en  = w_read_en && !rst;
  assign bus.flush_busy    = (r_state == ST_FLUSH);
  assign bus.tx_valid      = r_tx_valid;
  assign bus.tx_data       = r_tx_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_rr_ptr   <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_read_en      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.flush) begin
          w_state_nxt = ST_FLUSH;
        end else if (bus.enable && !bus.fifo_empty) begin
          w_read_en   = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (bus.flush) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_tx_data_nxt  = bus.fifo_data_out;
          w_tx_valid_nxt = 1'b1;
          w_state_nxt    = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // tx_valid drops on every exit so an accepted byte is never re-offered.
        if (bus.flush) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = ST_FLUSH;
        end else if (bus.tx_ready && bus.enable && !bus.fifo_empty) begin
          w_read_en      = 1'b1;
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = ST_FETCH;
        end else if (bus.tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        w_tx_valid_nxt = 1'b0;
        w_read_en      = !bus.fifo_empty;
        if (bus.fifo_empty && !bus.flush) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo_ctrl.sv
// +------------------------------------------------------------------+
// | tb_uart_tx_fifo_ctrl : self-checking bench with a queue FIFO model |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_fifo_ctrl;

  localparam int NREQ = 2;
  localparam int W    = 8;
  localparam int DEP  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_ctrl_if #(.NUM_REQ(NREQ), .WIDTH(W)) bus ();

  uart_tx_fifo_ctrl #(.NUM_REQ(NREQ), .WIDTH(W), .DEPTH(DEP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stimulus-side signals
  logic [NREQ-1:0] req = '0;
  logic [W-1:0]    rd [NREQ];
  logic            enable = 1'b0, flush = 1'b0, tx_ready = 1'b0, full_force = 1'b0;

  assign bus.req      = req;
  assign bus.req_data = {rd[1], rd[0]};
  assign bus.enable   = enable;
  assign bus.flush    = flush;
  assign bus.tx_ready = tx_ready;

  // Behavioural FIFO: pop lands on fifo_data_out the cycle after read_en
  logic [W-1:0] fq[$];
  logic         m_empty, m_full;
  logic [W-1:0] fdo;
  assign bus.fifo_full     = m_full | full_force;
  assign bus.fifo_empty    = m_empty;
  assign bus.fifo_data_out = fdo;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      m_empty <= 1'b1;
      m_full  <= 1'b0;
      fdo     <= '0;
    end else begin
      if (bus.fifo_read_en && fq.size() > 0) fdo <= fq.pop_front();
      if (bus.fifo_write_en && fq.size() < DEP) fq.push_back(bus.fifo_data_in);
      m_empty <= (fq.size() == 0);
      m_full  <= (fq.size() == DEP);
    end
  end

  // Transmitter-side monitor and protocol invariants
  int           cyc = 0;
  logic [W-1:0] acc[$];
  int           acc_cyc[$];
  int           rd_viol = 0, wr_viol = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus.tx_valid && tx_ready) begin
        acc.push_back(bus.tx_data);
        acc_cyc.push_back(cyc);
      end
      if (bus.fifo_read_en && bus.fifo_empty) rd_viol++;
      if (bus.fifo_write_en && bus.fifo_full) wr_viol++;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Spec-level round-robin: first requester at or after the pointer, with wrap.
  function automatic logic [NREQ-1:0] model_gnt(input logic [NREQ-1:0] r, input int p,
                                                input logic blocked);
    logic [NREQ-1:0] g;
    g = '0;
    if (!blocked) begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (p + k) % NREQ;
        if (r[i] && g == '0) g[i] = 1'b1;
      end
    end
    return g;
  endfunction

  task automatic write_byte(input int who, input logic [W-1:0] v);
    int n;
    n = 0;
    @(negedge clk);
    req      = '0;
    req[who] = 1'b1;
    rd[who]  = v;
    #1;
    while (!bus.gnt[who] && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("write_grant", bus.gnt[who], 1'b1);
    @(posedge clk);
    #1 req = '0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!bus.tx_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(name, bus.tx_valid, 1'b1);
  endtask

  task automatic wait_acc(input string name, input int cnt);
    int n;
    n = 0;
    while (acc.size() < cnt && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, acc.size(), cnt);
  endtask

  typedef struct {
    logic [NREQ-1:0] req;
    logic            full;
    logic [NREQ-1:0] gnt;
  } arb_vec_t;

  arb_vec_t     vecs[8];
  logic [W-1:0] exp_q[$];

  initial begin
    logic [NREQ-1:0] eg, last_g;
    int              mptr, bad;

    vecs[0] = '{2'b11, 1'b0, 2'b01};
    vecs[1] = '{2'b11, 1'b0, 2'b10};
    vecs[2] = '{2'b11, 1'b0, 2'b01};
    vecs[3] = '{2'b11, 1'b0, 2'b10};
    vecs[4] = '{2'b01, 1'b1, 2'b00};
    vecs[5] = '{2'b01, 1'b0, 2'b01};
    vecs[6] = '{2'b10, 1'b0, 2'b10};
    vecs[7] = '{2'b01, 1'b0, 2'b01};

    rd[0] = 8'h11;
    rd[1] = 8'h22;

    // Reset state, with a live request that must not be granted
    req = 2'b11;
    enable = 1'b1;
    #12;
    check("rst_gnt", bus.gnt, 2'b00);
    check("rst_write_en", bus.fifo_write_en, 1'b0);
    check("rst_read_en", bus.fifo_read_en, 1'b0);
    check("rst_tx_valid", bus.tx_valid, 1'b0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_flush_busy", bus.flush_busy, 1'b0);
    req = '0;
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Arbitration table: alternation, full blocking, same-cycle release
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      req        = vecs[v].req;
      full_force = vecs[v].full;
      #1;
      check($sformatf("arb_gnt[%0d]", v), bus.gnt, vecs[v].gnt);
      check($sformatf("arb_wen[%0d]", v), bus.fifo_write_en, |vecs[v].gnt);
      if (vecs[v].gnt != '0)
        check($sformatf("arb_data[%0d]", v), bus.fifo_data_in, vecs[v].gnt[1] ? 8'h22 : 8'h11);
    end
    @(negedge clk);
    req        = '0;
    full_force = 1'b0;
    exp_q = '{8'h11, 8'h22, 8'h11, 8'h22, 8'h11, 8'h22, 8'h11};
    check("fifo_count", fq.size(), 7);
    bad = 0;
    for (int k = 0; k < 7 && k < fq.size(); k++) if (fq[k] !== exp_q[k]) bad++;
    check("fifo_contents", bad, 0);

    // Drain those bytes in order
    acc.delete();
    acc_cyc.delete();
    enable   = 1'b1;
    tx_ready = 1'b1;
    wait_acc("drain7_count", 7);
    bad = 0;
    for (int k = 0; k < 7 && k < acc.size(); k++) if (acc[k] !== exp_q[k]) bad++;
    check("drain7_order", bad, 0);
    @(negedge clk);
    enable   = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Latency and hold stability
    write_byte(0, 8'hA5);
    @(negedge clk);
    enable = 1'b1;
    #1 check("lat_cycle0", bus.tx_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle1", bus.tx_valid, 1'b0);
    @(negedge clk);
    check("lat_cycle2", bus.tx_valid, 1'b1);
    check("lat_data", bus.tx_data, 8'hA5);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid[%0d]", k), bus.tx_valid, 1'b1);
      check($sformatf("hold_data[%0d]", k), bus.tx_data, 8'hA5);
    end
    acc.delete();
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    #1 check("ready_drop_valid", bus.tx_valid, 1'b0);
    check("ready_accept_count", acc.size(), 1);
    enable = 1'b0;

    // Fill to DEPTH, confirm full blocks writes, then full-rate drain
    for (int v = 0; v < 16; v++) write_byte(1, 8'(v));
    @(negedge clk);
    req = 2'b01;
    #1 check("full_gnt", bus.gnt, 2'b00);
    check("full_flag", bus.fifo_full, 1'b1);
    req = '0;
    acc.delete();
    acc_cyc.delete();
    enable   = 1'b1;
    tx_ready = 1'b1;
    wait_acc("seq16_count", 16);
    bad = 0;
    for (int k = 0; k < acc.size(); k++) if (acc[k] !== 8'(k)) bad++;
    check("seq16_order", bad, 0);
    bad = 0;
    for (int k = 1; k < acc_cyc.size(); k++) if (acc_cyc[k] - acc_cyc[k-1] != 2) bad++;
    check("seq16_spacing", bad, 0);
    @(negedge clk);
    enable   = 1'b0;
    tx_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Flush from HOLD with 8 queued
    for (int v = 0; v < 8; v++) write_byte(0, 8'h40 + 8'(v));
    @(negedge clk);
    enable = 1'b1;
    wait_valid("flush_pre_hold");
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1 check("flush_valid_drop", bus.tx_valid, 1'b0);
    check("flush_busy_set", bus.flush_busy, 1'b1);
    req = 2'b11;
    for (int n = 0; n < 50 && bus.flush_busy; n++) begin
      check("flush_no_gnt", bus.gnt, 2'b00);
      @(negedge clk);
      #1;
    end
    check("flush_busy_clear", bus.flush_busy, 1'b0);
    check("flush_fifo_empty", fq.size(), 0);
    req = '0;
    check("flush_idle_valid", bus.tx_valid, 1'b0);
    @(negedge clk);
    enable = 1'b0;

    // Async reset mid-HOLD, then mid-FLUSH; pointer returns to 0
    write_byte(0, 8'h3C);
    @(negedge clk);
    enable = 1'b1;
    wait_valid("rst_pre_hold");
    #2 rst = 1'b1;
    #1 check("arst_tx_valid", bus.tx_valid, 1'b0);
    check("arst_tx_data", bus.tx_data, 8'h00);
    check("arst_read_en", bus.fifo_read_en, 1'b0);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b0;
    flush  = 1'b1;
    repeat (3) @(negedge clk);
    check("arst_pre_flush_busy", bus.flush_busy, 1'b1);
    #2 rst = 1'b1;
    #1 check("arst_flush_busy", bus.flush_busy, 1'b0);
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    req = 2'b11;
    #1 check("arst_tie_gnt", bus.gnt, 2'b01);
    @(posedge clk);
    #1 req = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Randomised traffic against the spec-level arbiter and ordering model
    acc.delete();
    exp_q.delete();
    mptr   = 0;
    last_g = '0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] || last_g[i]) begin
          req[i] = ($urandom_range(0, 2) == 0);
          rd[i]  = 8'($urandom);
        end
      end
      enable   = ($urandom_range(0, 3) != 0);
      tx_ready = $urandom_range(0, 1) == 1;
      #1;
      eg = model_gnt(req, mptr, bus.fifo_full);
      check("rand_gnt", bus.gnt, eg);
      if (eg != '0) begin
        check("rand_wdata", bus.fifo_data_in, eg[1] ? rd[1] : rd[0]);
        exp_q.push_back(eg[1] ? rd[1] : rd[0]);
        mptr = eg[1] ? 0 : 1;
      end
      last_g = eg;
    end
    @(negedge clk);
    req      = '0;
    enable   = 1'b1;
    tx_ready = 1'b1;
    wait_acc("rand_count", exp_q.size());
    bad = 0;
    for (int k = 0; k < exp_q.size() && k < acc.size(); k++) if (acc[k] !== exp_q[k]) bad++;
    check("rand_order", bad, 0);

    check("read_while_empty", rd_viol, 0);
    check("write_while_full", wr_viol, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
